spu_byte_unit: RTL

Parametrised SPU byte execution pipe. Executes the RR-format byte instructions cntb, avgb, absdb and sumb on WIDTH-bit register values. Results pass through a configurable-depth delay pipeline to the write-back interface. Every in-flight stage is exported for the forwarding network, and in-flight instructions can be squashed by a branch flush.

---
 rtl/spu_pkg.sv | 40 ++++
 rtl/spu_byte_alu.sv | 68 ++++++
 rtl/spu_byte_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// Shared definitions for the SPU byte pipe: RR opcodes, format codes and the
// decoded operation kind handed from the issue decode to the byte ALU.
package spu_pkg;

  localparam logic [0:10] OP_NOP   = 11'b00000000000;
  localparam logic [0:10] OP_CNTB  = 11'b01010110100;
  localparam logic [0:10] OP_AVGB  = 11'b00011010011;
  localparam logic [0:10] OP_ABSDB = 11'b00001010011;
  localparam logic [0:10] OP_SUMB  = 11'b01001010011;

  localparam logic [2:0] FMT_RR  = 3'd0;
  localparam logic [2:0] FMT_RRR = 3'd1;
  localparam logic [2:0] FMT_RI  = 3'd2;

  typedef enum logic [2:0] {
    KIND_NONE,
    KIND_CNTB,
    KIND_AVGB,
    KIND_ABSDB,
    KIND_SUMB
  } op_kind_e;

  // Anything that is not one of the four RR byte ops decodes to KIND_NONE,
  // which the pipe turns into a bubble.
  function automatic op_kind_e decode_op(input logic [2:0] fmt, input logic [0:10] opc);
    op_kind_e kind;
    kind = KIND_NONE;
    if (fmt == FMT_RR) begin
      case (opc)
        OP_CNTB:  kind = KIND_CNTB;
        OP_AVGB:  kind = KIND_AVGB;
        OP_ABSDB: kind = KIND_ABSDB;
        OP_SUMB:  kind = KIND_SUMB;
        default:  kind = KIND_NONE;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/spu_byte_alu.sv
// Combinational byte ALU: per-byte cntb/avgb/absdb and per-word sumb, picked
// by the decoded operation kind.
module spu_byte_alu
  import spu_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  op_kind_e          kind,
  input  logic [WIDTH-1:0]  ra,
  input  logic [WIDTH-1:0]  rb,
  output logic [WIDTH-1:0]  result
);

  localparam int BYTES = WIDTH / 8;
  localparam int WORDS = WIDTH / 32;

  logic [WIDTH-1:0] cnt_vec;
  logic [WIDTH-1:0] avg_vec;
  logic [WIDTH-1:0] absd_vec;
  logic [WIDTH-1:0] sum_vec;

  genvar gi;

  for (gi = 0; gi < BYTES; gi++) begin : gen_byte
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [3:0] ones;

    assign a_byte = ra[8*gi +: 8];
    assign b_byte = rb[8*gi +: 8];

    always_comb begin
      ones = '0;
      for (int i = 0; i < 8; i++) begin
        ones = ones + {3'b000, a_byte[i]};
      end
    end

    assign cnt_vec[8*gi +: 8]  = {4'b0000, ones};
    // (a+b+1)>>1 rewritten as halves plus the rounding bit; never exceeds 8 bits.
    assign avg_vec[8*gi +: 8]  = (a_byte >> 1) + (b_byte >> 1) + {7'b0, a_byte[0] | b_byte[0]};
    assign absd_vec[8*gi +: 8] = (a_byte > b_byte) ? (a_byte - b_byte) : (b_byte - a_byte);
  end

  for (gi = 0; gi < WORDS; gi++) begin : gen_word
    logic [9:0] sum_a;
    logic [9:0] sum_b;

    assign sum_a = {2'b00, ra[32*gi+31 -: 8]} + {2'b00, ra[32*gi+23 -: 8]}
                 + {2'b00, ra[32*gi+15 -: 8]} + {2'b00, ra[32*gi+7 -: 8]};
    assign sum_b = {2'b00, rb[32*gi+31 -: 8]} + {2'b00, rb[32*gi+23 -: 8]}
                 + {2'b00, rb[32*gi+15 -: 8]} + {2'b00, rb[32*gi+7 -: 8]};
    // Upper halfword carries the rb sum, lower halfword the ra sum.
    assign sum_vec[32*gi +: 32] = {6'b000000, sum_b, 6'b000000, sum_a};
  end

  always_comb begin
    result = '0;
    case (kind)
      KIND_CNTB:  result = cnt_vec;
      KIND_AVGB:  result = avg_vec;
      KIND_ABSDB: result = absd_vec;
      KIND_SUMB:  result = sum_vec;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/spu_byte_unit.sv
// SPU byte execution pipe: issue decode, LATENCY-1 forwarded result stages,
// a final hand-off register and the write-back port, with branch-flush squash.
module spu_byte_unit
  import spu_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [0:10]                   op,
  input  logic [2:0]                    format,
  input  logic [ADDR_W-1:0]             rt_addr,
  input  logic [WIDTH-1:0]              ra,
  input  logic [WIDTH-1:0]              rb,
  input  logic                          reg_write,
  input  logic                          flush,
  output logic [WIDTH-1:0]              rt_wb,
  output logic [ADDR_W-1:0]             rt_addr_wb,
  output logic                          reg_write_wb,
  output logic [(LATENCY-1)*WIDTH-1:0]  fwd_rt,
  output logic [(LATENCY-1)*ADDR_W-1:0] fwd_addr,
  output logic [LATENCY-2:0]            fwd_valid
);

  localparam int STAGES = LATENCY - 1;

  typedef struct packed {
    logic [WIDTH-1:0]  value;
    logic [ADDR_W-1:0] addr;
    logic              valid;
  } stage_t;

  op_kind_e         kind;
  logic [WIDTH-1:0] alu_result;
  stage_t           issue_stage;
  stage_t           stage_reg [STAGES];
  stage_t           tail_reg;

  assign kind = decode_op(format, op);

  spu_byte_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .kind   (kind),
    .ra     (ra),
    .rb     (rb),
    .result (alu_result)
  );

  always_comb begin
    issue_stage = '0;
    if (kind != KIND_NONE) begin
      issue_stage.value = alu_result;
      issue_stage.addr  = rt_addr;
      issue_stage.valid = reg_write;
    end
  end

  genvar gi;

  for (gi = 0; gi < STAGES; gi++) begin : gen_stage
    stage_t stage_src;

    if (gi == 0) begin : gen_head
      assign stage_src = issue_stage;
    end else begin : gen_link
      assign stage_src = stage_reg[gi-1];
    end

    // A flush only kills the valid bit; value and address keep flowing.
    always_ff @(posedge clk) begin
      if (reset) begin
        stage_reg[gi] <= '0;
      end else begin
        stage_reg[gi] <= stage_src;
        if (flush) begin
          stage_reg[gi].valid <= 1'b0;
        end
      end
    end

    assign fwd_rt[gi*WIDTH +: WIDTH]     = stage_reg[gi].value;
    assign fwd_addr[gi*ADDR_W +: ADDR_W] = stage_reg[gi].addr;
    assign fwd_valid[gi]                 = stage_reg[gi].valid;
  end

  // The tail slot sits between the last forwarded stage and write-back so
  // that an instruction issued at edge N writes back at edge N+LATENCY.
  always_ff @(posedge clk) begin
    if (reset) begin
      tail_reg     <= '0;
      rt_wb        <= '0;
      rt_addr_wb   <= '0;
      reg_write_wb <= 1'b0;
    end else begin
      tail_reg <= stage_reg[STAGES-1];
      if (flush) begin
        tail_reg.valid <= 1'b0;
      end
      rt_wb        <= tail_reg.value;
      rt_addr_wb   <= tail_reg.addr;
      reg_write_wb <= tail_reg.valid & ~flush;
    end
  end

endmodule
